// File: rtl/sync_fifo_buffer_pkg.sv
// Shared FIFO helpers: pointer-width derivation and threshold legality checks,
// usable by both synchronous and asynchronous FIFO variants.
package sync_fifo_buffer_pkg;

    function automatic int unsigned fifo_clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    function automatic bit fifo_depth_ok(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit fifo_af_ok(input int unsigned af, input int unsigned depth);
        return (af >= 1) && (af <= depth);
    endfunction

    function automatic bit fifo_ae_ok(input int unsigned ae, input int unsigned depth);
        return ae <= depth - 1;
    endfunction

endpackage

// File: rtl/sync_fifo_buffer_if.sv
// FIFO stream/status bundle; slave is the FIFO, master is the user side.
interface sync_fifo_buffer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   fill_level;
    logic                  overflow;
    logic                  underflow;
    logic                  clr_err;

    modport slave (
        input  flush, wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               fill_level, overflow, underflow
    );

    modport master (
        output flush, wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               fill_level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write, combinational read.
module sync_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = mem_q[raddr_i];
    end
endmodule

// File: rtl/sync_fifo_buffer.sv
// Single-clock FIFO with occupancy flags, FWFT or registered read,
// flush and sticky overflow/underflow flags.
module sync_fifo_buffer
    import sync_fifo_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_THRESH  = 6,
    parameter int unsigned AE_THRESH  = 1,
    parameter int unsigned FWFT       = 1
) (
    input  logic               CLK,
    input  logic               RST,
    sync_fifo_buffer_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);

    if (!fifo_depth_ok(FIFO_DEPTH) || ADDR_WIDTH != fifo_clog2(FIFO_DEPTH)) begin : g_bad_depth
        $error("sync_fifo_buffer: FIFO_DEPTH/ADDR_WIDTH inconsistent");
    end
    if (!fifo_af_ok(AF_THRESH, FIFO_DEPTH) || !fifo_ae_ok(AE_THRESH, FIFO_DEPTH)) begin : g_bad_thresh
        $error("sync_fifo_buffer: AF_THRESH/AE_THRESH out of range");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, ram_rdata;
    logic                  rd_valid_q, rd_valid_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  full, empty, wr_acc, rd_acc;

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .CLK     (CLK),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        full   = (count_q == DEPTH_C);
        empty  = (count_q == '0);
        // flush masks both accepts so neither memory nor pointers move on that edge
        wr_acc = bus.wr_en & ~full  & ~bus.flush;
        rd_acc = bus.rd_en & ~empty & ~bus.flush;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        ovf_d      = ovf_q;
        udf_d      = udf_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                rd_data_d  = ram_rdata;
                rd_valid_d = 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            ovf_d = (ovf_q & ~bus.clr_err) | (bus.wr_en & full);
            udf_d = (udf_q & ~bus.clr_err) | (bus.rd_en & empty);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    always_comb begin
        if (FWFT != 0) begin
            // head word is gated to zero while empty so the output is defined after reset
            bus.rd_data  = empty ? '0 : ram_rdata;
            bus.rd_valid = ~empty;
        end else begin
            bus.rd_data  = rd_data_q;
            bus.rd_valid = rd_valid_q;
        end
        bus.full         = full;
        bus.empty        = empty;
        bus.almost_full  = (count_q >= AF_C);
        bus.almost_empty = (count_q <= AE_C);
        bus.fill_level   = count_q;
        bus.overflow     = ovf_q;
        bus.underflow    = udf_q;
    end
endmodule
